// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator with glitch-free tuning-word handover at wrap; phase_out and wrap lag acc by one cycle.
// Optional phase dither is compiled in with `define NCO_DITHER_EN; the default build has no LFSR.
module nco_phase_accumulator #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] phase_off,
  output logic [PHASE_W-1:0] phase_out,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_active_ftw;
  logic [ACC_W-1:0]   r_pend_ftw;
  logic               r_carry;
  logic [PHASE_W-1:0] r_phase;
  logic               r_wrap;

  logic [ACC_W:0]     w_sum;
  logic               w_adv;
  logic               w_carry;
  logic               w_xfer;
  logic               w_load_in;
  logic               w_store_pend;
  logic               w_apply_pend;
  logic [PHASE_W-1:0] w_phase_top;

  assign ftw_ready = (r_state != PEND);
  assign w_xfer    = ftw_valid & ftw_ready;
  assign w_adv     = en & (r_state != IDLE);
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_active_ftw};
  // clr outranks a coincident carry: the wrap pulse is dropped, not delayed.
  assign w_carry   = w_adv & w_sum[ACC_W] & ~clr;

  always_comb begin
    w_state_nxt  = r_state;
    w_load_in    = 1'b0;
    w_store_pend = 1'b0;
    w_apply_pend = 1'b0;
    case (r_state)
      IDLE: begin
        w_load_in = w_xfer;
        if (en) w_state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          w_load_in   = w_xfer;
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_store_pend = 1'b1;
          w_state_nxt  = PEND;
        end
      end
      PEND: begin
        if (clr || w_carry) begin
          w_apply_pend = 1'b1;
          w_state_nxt  = RUN;
        end else if (!en) begin
          w_apply_pend = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_active_ftw <= '0;
      r_pend_ftw   <= '0;
      r_carry      <= 1'b0;
    end else begin
      if (clr)        r_acc <= '0;
      else if (w_adv) r_acc <= w_sum[ACC_W-1:0];
      if (w_load_in)         r_active_ftw <= ftw_in;
      else if (w_apply_pend) r_active_ftw <= r_pend_ftw;
      if (w_store_pend) r_pend_ftw <= ftw_in;
      r_carry <= w_carry;
    end
  end

`ifdef NCO_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic        w_dith_cy;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form (taps at bits 0,2,3,5).
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_lfsr <= 16'hACE1;
    else if (en) r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
  end

  // Only the carry of the dither add into the phase bits matters: a + b overflows iff b > ~a.
  assign w_dith_cy   = (r_lfsr[ACC_W-PHASE_W-1:0] > ~r_acc[ACC_W-PHASE_W-1:0]);
  assign w_phase_top = r_acc[ACC_W-1 -: PHASE_W] + {{(PHASE_W-1){1'b0}}, w_dith_cy};
`else
  assign w_phase_top = r_acc[ACC_W-1 -: PHASE_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_phase <= w_phase_top + phase_off;
      r_wrap  <= r_carry;
    end
  end

  assign phase_out = r_phase;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed self-checking bench for nco_phase_accumulator (ACC_W=24, no dither).
module tb_nco_phase_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [23:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [7:0]  phase_off;
  logic [7:0]  phase_out;
  logic        wrap;

  int tests = 0;
  int fails = 0;

  nco_phase_accumulator #(.ACC_W(24), .PHASE_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .ftw_in    (ftw_in),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .phase_off (phase_off),
    .phase_out (phase_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; ftw_in = '0; ftw_valid = 1'b0; phase_off = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Load a word in IDLE, enable, and advance to the first cycle showing acc=0 (acc already stepped once).
  task automatic start_run(input logic [23:0] ftw);
    ftw_in = ftw; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0; en = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ftw_in = '0; ftw_valid = 1'b0; phase_off = '0;
    #3;
    tests++; if (phase_out !== 8'h00) begin fails++; $display("FAIL reset_phase got %h exp 00", phase_out); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    tests++; if (ftw_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ftw_ready); end
    do_reset();
  endtask

  task automatic test_step();
    logic [7:0] exp_ph;
    do_reset();
    start_run(24'h010000);
    tests++; if (phase_out !== 8'h00) begin fails++; $display("FAIL step_first got %h exp 00", phase_out); end
    for (int i = 1; i <= 256; i++) begin
      step();
      exp_ph = 8'(i);
      tests++; if (phase_out !== exp_ph) begin fails++; $display("FAIL step_phase i=%0d got %h exp %h", i, phase_out, exp_ph); end
      tests++; if (wrap !== (i == 256)) begin fails++; $display("FAIL step_wrap i=%0d got %b exp %b", i, wrap, (i == 256)); end
    end
    en = 1'b0;
    step();
    tests++; if (phase_out !== 8'h01) begin fails++; $display("FAIL freeze_a got %h exp 01", phase_out); end
    step(); step();
    tests++; if (phase_out !== 8'h01) begin fails++; $display("FAIL freeze_b got %h exp 01", phase_out); end
  endtask

  task automatic test_offset();
    logic [7:0] exp_ph;
    do_reset();
    phase_off = 8'h10;
    start_run(24'h400000);
    tests++; if (phase_out !== 8'h10) begin fails++; $display("FAIL offset_first got %h exp 10", phase_out); end
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_ph = 8'h10 + 8'(i * 64);
      tests++; if (phase_out !== exp_ph) begin fails++; $display("FAIL offset_phase i=%0d got %h exp %h", i, phase_out, exp_ph); end
      tests++; if (wrap !== (i % 4 == 0)) begin fails++; $display("FAIL offset_wrap i=%0d got %b exp %b", i, wrap, (i % 4 == 0)); end
    end
  endtask

  task automatic test_pend();
    do_reset();
    start_run(24'h400000);
    step();
    tests++; if (phase_out !== 8'h40) begin fails++; $display("FAIL pend_pre got %h exp 40", phase_out); end
    ftw_in = 24'h800000; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    tests++; if (ftw_ready !== 1'b0) begin fails++; $display("FAIL pend_ready_low got %b exp 0", ftw_ready); end
    tests++; if (phase_out !== 8'h80) begin fails++; $display("FAIL pend_old_step got %h exp 80", phase_out); end
    step();
    tests++; if (phase_out !== 8'hC0) begin fails++; $display("FAIL pend_old_step2 got %h exp C0", phase_out); end
    tests++; if (ftw_ready !== 1'b1) begin fails++; $display("FAIL pend_ready_back got %b exp 1", ftw_ready); end
    step();
    tests++; if (phase_out !== 8'h00 || wrap !== 1'b1) begin fails++; $display("FAIL pend_wrap got %h/%b exp 00/1", phase_out, wrap); end
    step();
    tests++; if (phase_out !== 8'h80 || wrap !== 1'b0) begin fails++; $display("FAIL pend_new_step got %h/%b exp 80/0", phase_out, wrap); end
    step();
    tests++; if (phase_out !== 8'h00 || wrap !== 1'b1) begin fails++; $display("FAIL pend_new_wrap got %h/%b exp 00/1", phase_out, wrap); end
  endtask

  task automatic test_clr_wrap();
    do_reset();
    phase_off = 8'h20;
    start_run(24'h400000);
    step(); step();
    tests++; if (phase_out !== 8'hA0) begin fails++; $display("FAIL clrw_pre got %h exp A0", phase_out); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests++; if (phase_out !== 8'hE0) begin fails++; $display("FAIL clrw_edge got %h exp E0", phase_out); end
    step();
    tests++; if (phase_out !== 8'h20) begin fails++; $display("FAIL clrw_phase got %h exp 20", phase_out); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL clrw_nowrap got %b exp 0", wrap); end
    step();
    tests++; if (phase_out !== 8'h60 || wrap !== 1'b0) begin fails++; $display("FAIL clrw_next got %h/%b exp 60/0", phase_out, wrap); end
  endtask

  task automatic test_clr_pend();
    do_reset();
    start_run(24'h400000);
    step();
    ftw_in = 24'h100000; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    tests++; if (ftw_ready !== 1'b0) begin fails++; $display("FAIL clrp_pend got %b exp 0", ftw_ready); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests++; if (ftw_ready !== 1'b1) begin fails++; $display("FAIL clrp_ready got %b exp 1", ftw_ready); end
    step();
    tests++; if (phase_out !== 8'h00) begin fails++; $display("FAIL clrp_zero got %h exp 00", phase_out); end
    step();
    tests++; if (phase_out !== 8'h10) begin fails++; $display("FAIL clrp_step1 got %h exp 10", phase_out); end
    step();
    tests++; if (phase_out !== 8'h20) begin fails++; $display("FAIL clrp_step2 got %h exp 20", phase_out); end
  endtask

  task automatic test_reset_pend();
    do_reset();
    start_run(24'h400000);
    step();
    ftw_in = 24'h800000; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (phase_out !== 8'h00 || wrap !== 1'b0) begin fails++; $display("FAIL rstp_out got %h/%b exp 00/0", phase_out, wrap); end
    tests++; if (ftw_ready !== 1'b1) begin fails++; $display("FAIL rstp_ready got %b exp 1", ftw_ready); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      tests++; if (phase_out !== 8'h00 || wrap !== 1'b0) begin fails++; $display("FAIL rstp_stale i=%0d got %h/%b exp 00/0", i, phase_out, wrap); end
    end
    phase_off = 8'h33;
    step();
    tests++; if (phase_out !== 8'h33) begin fails++; $display("FAIL rstp_offset got %h exp 33", phase_out); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_offset();
    test_pend();
    test_clr_wrap();
    test_clr_pend();
    test_reset_pend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nco_phase_accumulator.md
NCO_PHASE_ACCUMULATOR -- requirements
Module: nco_phase_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, accumulator width; legal range 16..24.
REQ-002 The block SHALL have parameter PHASE_W, fixed at 8: width of the phase output that feeds the sine LUT stage.
REQ-003 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 en  in  1  run enable; low freezes the accumulator.
REQ-006 clr  in  1  synchronous single-cycle accumulator clear.
REQ-007 ftw_in  in  ACC_W  frequency tuning word, unsigned.
REQ-008 ftw_valid  in  1  ftw_in is valid.
REQ-009 ftw_ready  out  1  the block can accept a tuning word.
REQ-010 phase_off  in  8  phase offset, added modulo 256.
REQ-011 phase_out  out  8  registered phase to the downstream sine stage.
REQ-012 wrap  out  1  one-cycle pulse marking an accumulator overflow.

Function
REQ-013 FSM states SHALL be IDLE, RUN and PEND (pending tuning word).
REQ-014 A transfer SHALL occur in any cycle where ftw_valid=1 and ftw_ready=1.
REQ-015 ftw_ready SHALL be 1 in IDLE and RUN, and 0 in PEND.
REQ-016 IDLE: a transfer SHALL load active_ftw on the next edge; en=1 SHALL move the FSM to RUN.
REQ-017 RUN: a transfer SHALL store the word in pend_ftw and move the FSM to PEND; active_ftw SHALL stay unchanged, giving a glitch-free frequency change.
REQ-018 PEND: on the cycle the accumulator wraps, active_ftw SHALL take pend_ftw and the FSM SHALL return to RUN.
REQ-019 RUN or PEND with en=0: any pending word SHALL be applied immediately and the FSM SHALL go to IDLE.
REQ-020 When en=1 and the FSM is not in IDLE, acc SHALL be updated to (acc + active_ftw) mod 2^ACC_W every cycle.
REQ-021 Carry out of that addition SHALL be the wrap event; wrap SHALL be registered so it goes high in the same cycle phase_out shows the wrapped value.
REQ-022 phase_out SHALL be registered as acc[ACC_W-1:ACC_W-8] + phase_off, mod 256, giving one cycle of latency from acc.
REQ-023 clr=1 SHALL set acc to 0 and SHALL suppress wrap for that cycle.
REQ-024 clr=1 in PEND SHALL apply pend_ftw and move the FSM to RUN.
REQ-025 clr SHALL take priority over en and over a simultaneous wrap event.
REQ-026 phase_off changes SHALL take effect on phase_out after one cycle, with no effect on acc.
REQ-027 ftw_in=0 SHALL hold the phase constant, and SHALL leave a PEND state waiting until en=0 or clr.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: acc, active_ftw and pend_ftw = 0; phase_out = 8'h00; wrap = 0; ftw_ready = 1; FSM = IDLE.
REQ-029 Reset asserted mid-operation SHALL discard any pending word.
REQ-030 The first accumulate after reset release SHALL occur on the first edge with en=1 and the FSM in RUN.

Configuration
REQ-031 Macro NCO_DITHER_EN: when defined, a 16-bit Fibonacci LFSR SHALL be compiled in.
REQ-032 The LFSR polynomial SHALL be x^16+x^14+x^13+x^11+1, with seed 16'hACE1 at reset.
REQ-033 The LFSR SHALL advance every cycle that en=1.
REQ-034 With NCO_DITHER_EN defined, the phase SHALL be taken from (acc + lfsr[ACC_W-9:0]) mod 2^ACC_W before truncation to 8 bits; wrap detection SHALL be unaffected.
REQ-035 Without NCO_DITHER_EN, no LFSR logic SHALL exist and phase_out SHALL follow REQ-022 exactly.

Verification (ACC_W=24, NCO_DITHER_EN undefined unless stated)
REQ-036 Load ftw 0x010000 in IDLE, then en=1 -> phase_out steps 00,01,02,... by one per cycle; wrap pulses once every 256 cycles, when phase_out=00.
REQ-037 ftw 0x400000 with phase_off=0x10 -> phase_out repeats 10,50,90,D0; wrap is high on every cycle where phase_out=10.
REQ-038 While running with ftw 0x400000, offer ftw 0x800000 mid-period -> ftw_ready drops to 0; the step stays 0x40 until the next wrap, then becomes 0x80; ftw_ready returns to 1.
REQ-039 Assert clr on the same cycle as a wrap -> acc=0, no wrap pulse; the next phase_out is phase_off.
REQ-040 Assert rst_n=0 while in PEND -> outputs are zero immediately; ftw_ready=1; the old pending word is never applied after release.
REQ-041 With NCO_DITHER_EN defined and ftw=0, en=1 -> phase_out varies by at most 1 LSB around its held value, and wrap never pulses.
